wb_arbiter2: RTL and testbench

WB_ARBITER2 -- requirements
Module: wb_arbiter2

---
 rtl/wb_arbiter2.sv | 137 +++++++++++++
 tb/tb_wb_arbiter2.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master Wishbone arbiter for a shared RAM slave; WB_ARBITER_RR_EN selects round-robin contention
module wb_arbiter2 (
  input  logic        clk_i,
  input  logic        rst_i,
  // master 0
  input  logic [31:0] m0_wb_dat_i,
  output logic [31:0] m0_wb_dat_o,
  input  logic [31:2] m0_wb_adr_i,
  input  logic        m0_wb_we_i,
  input  logic [3:0]  m0_wb_sel_i,
  input  logic        m0_wb_cyc_i,
  input  logic        m0_wb_stb_i,
  input  logic [2:0]  m0_wb_cti_i,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_stall_o,
  // master 1
  input  logic [31:0] m1_wb_dat_i,
  output logic [31:0] m1_wb_dat_o,
  input  logic [31:2] m1_wb_adr_i,
  input  logic        m1_wb_we_i,
  input  logic [3:0]  m1_wb_sel_i,
  input  logic        m1_wb_cyc_i,
  input  logic        m1_wb_stb_i,
  input  logic [2:0]  m1_wb_cti_i,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_stall_o,
  // shared slave
  output logic [31:0] s_wb_dat_o,
  output logic [31:2] s_wb_adr_o,
  output logic        s_wb_we_o,
  output logic [3:0]  s_wb_sel_o,
  output logic [2:0]  s_wb_cti_o,
  output logic        s_wb_cyc_o,
  output logic        s_wb_stb_o,
  input  logic [31:0] s_wb_dat_i,
  input  logic        s_wb_ack_i,
  input  logic        s_wb_stall_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  logic [1:0] state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic       gnt0, gnt1;
  logic       both_pick1;

  // Which master wins when both request from IDLE
  always_comb begin
`ifdef WB_ARBITER_RR_EN
    both_pick1 = ~last_owner_q;
`else
    // fixed priority to master 0; last_owner is kept up to date but has no effect here
    both_pick1 = last_owner_q & 1'b0;
`endif
  end

  // Grant decode: owner keeps the bus while its cyc is high, releasing owner hands over in the same cycle
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      ST_OWN0: begin
        if (!m0_wb_cyc_i && m1_wb_cyc_i) gnt1 = 1'b1;
        else                             gnt0 = 1'b1;
      end
      ST_OWN1: begin
        if (!m1_wb_cyc_i && m0_wb_cyc_i) gnt0 = 1'b1;
        else                             gnt1 = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state and last-owner tracking
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_wb_cyc_i && m1_wb_cyc_i) state_d = both_pick1 ? ST_OWN1 : ST_OWN0;
        else if (m0_wb_cyc_i)           state_d = ST_OWN0;
        else if (m1_wb_cyc_i)           state_d = ST_OWN1;
      end
      ST_OWN0: begin
        if (gnt1)              state_d = ST_OWN1;
        else if (!m0_wb_cyc_i) state_d = ST_IDLE;
      end
      ST_OWN1: begin
        if (gnt0)              state_d = ST_OWN0;
        else if (!m1_wb_cyc_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_OWN0 && state_q != ST_OWN0) last_owner_d = 1'b0;
    if (state_d == ST_OWN1 && state_q != ST_OWN1) last_owner_d = 1'b1;
  end

  // State registers; reset leaves master 1 as last owner so master 0 wins the first contention
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Request mux toward the slave and unregistered response routing back to the granted master
  always_comb begin
    s_wb_dat_o    = m0_wb_dat_i;
    s_wb_adr_o    = m0_wb_adr_i;
    s_wb_we_o     = m0_wb_we_i;
    s_wb_sel_o    = m0_wb_sel_i;
    s_wb_cti_o    = m0_wb_cti_i;
    s_wb_cyc_o    = gnt0 & m0_wb_cyc_i;
    s_wb_stb_o    = gnt0 & m0_wb_stb_i;
    if (gnt1) begin
      s_wb_dat_o  = m1_wb_dat_i;
      s_wb_adr_o  = m1_wb_adr_i;
      s_wb_we_o   = m1_wb_we_i;
      s_wb_sel_o  = m1_wb_sel_i;
      s_wb_cti_o  = m1_wb_cti_i;
      s_wb_cyc_o  = m1_wb_cyc_i;
      s_wb_stb_o  = m1_wb_stb_i;
    end
    m0_wb_dat_o   = s_wb_dat_i;
    m1_wb_dat_o   = s_wb_dat_i;
    m0_wb_ack_o   = gnt0 & s_wb_ack_i;
    m1_wb_ack_o   = gnt1 & s_wb_ack_i;
    m0_wb_stall_o = ~gnt0 | s_wb_stall_i;
    m1_wb_stall_o = ~gnt1 | s_wb_stall_i;
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb/tb_wb_arbiter2.sv - scoreboard bench for wb_arbiter2
`timescale 1ns/1ps
module tb_wb_arbiter2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        mcyc [2];
  logic        mstb [2];
  logic        mwe  [2];
  logic [29:0] madr [2];
  logic [31:0] mdat [2];
  logic [3:0]  msel [2];
  logic [2:0]  mcti [2];
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack, m1_ack, m0_stall, m1_stall;
  logic [31:0] s_dat_o;
  logic [29:0] s_adr_o;
  logic        s_we_o, s_cyc_o, s_stb_o;
  logic [3:0]  s_sel_o;
  logic [2:0]  s_cti_o;
  logic [31:0] s_dat_i = 32'h0;
  logic        s_ack_q = 1'b0;
  logic        ack_force = 1'b0;
  logic        s_stall = 1'b0;
  logic        s_ack_i;
  assign s_ack_i = s_ack_q | ack_force;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          beats_left [2];
  int          restarts_left [2];
  bit          pending [2];
  int          grant_code;
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];

  wb_arbiter2 dut (
    .clk_i(clk), .rst_i(rst),
    .m0_wb_dat_i(mdat[0]), .m0_wb_dat_o(m0_dat_o), .m0_wb_adr_i(madr[0]), .m0_wb_we_i(mwe[0]),
    .m0_wb_sel_i(msel[0]), .m0_wb_cyc_i(mcyc[0]), .m0_wb_stb_i(mstb[0]), .m0_wb_cti_i(mcti[0]),
    .m0_wb_ack_o(m0_ack), .m0_wb_stall_o(m0_stall),
    .m1_wb_dat_i(mdat[1]), .m1_wb_dat_o(m1_dat_o), .m1_wb_adr_i(madr[1]), .m1_wb_we_i(mwe[1]),
    .m1_wb_sel_i(msel[1]), .m1_wb_cyc_i(mcyc[1]), .m1_wb_stb_i(mstb[1]), .m1_wb_cti_i(mcti[1]),
    .m1_wb_ack_o(m1_ack), .m1_wb_stall_o(m1_stall),
    .s_wb_dat_o(s_dat_o), .s_wb_adr_o(s_adr_o), .s_wb_we_o(s_we_o), .s_wb_sel_o(s_sel_o),
    .s_wb_cti_o(s_cti_o), .s_wb_cyc_o(s_cyc_o), .s_wb_stb_o(s_stb_o),
    .s_wb_dat_i(s_dat_i), .s_wb_ack_i(s_ack_i), .s_wb_stall_i(s_stall)
  );

  // RAM-like slave: acks each strobe one cycle later, read data derived from the address
  always @(posedge clk) begin
    s_ack_q <= s_cyc_o & s_stb_o & ~s_ack_q;
    s_dat_i <= {s_adr_o, 2'b00} ^ 32'hA5A5_0000;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_exp(input int k, input logic [29:0] adr);
    if (k == 0) exp_q0.push_back({adr, 2'b00} ^ 32'hA5A5_0000);
    else        exp_q1.push_back({adr, 2'b00} ^ 32'hA5A5_0000);
  endtask

  task automatic start_xfer(input int k, input logic [29:0] adr, input int n, input logic we);
    madr[k] = adr;
    mdat[k] = {adr, 2'b00} ^ 32'h0F0F_0F0F;
    mwe[k]  = we;
    msel[k] = 4'hF;
    mcti[k] = (n == 1) ? 3'b000 : 3'b010;
    beats_left[k] = n;
    mcyc[k] = 1'b1;
    mstb[k] = 1'b1;
    push_exp(k, adr);
  endtask

  task automatic clear_masters();
    for (int k = 0; k < 2; k++) begin
      mcyc[k] = 1'b0; mstb[k] = 1'b0; mwe[k] = 1'b0; mcti[k] = 3'b000;
      msel[k] = 4'h0; mdat[k] = 32'h0;
      beats_left[k] = 0; restarts_left[k] = 0; pending[k] = 1'b0;
    end
    madr[0] = 30'h111;
    madr[1] = 30'h222;
    exp_q0.delete();
    exp_q1.delete();
    grant_code = 0;
  endtask

  // Scoreboard + master behaviour, called once per negedge
  task automatic service();
    logic        a [2];
    logic [31:0] d [2];
    logic [31:0] e;
    bit          empty;
    a[0] = m0_ack; a[1] = m1_ack;
    d[0] = m0_dat_o; d[1] = m1_dat_o;
    total_cnt++;
    if ((a[0] & a[1]) !== 1'b0) $display("FAIL dual_ack: m0_ack=%b m1_ack=%b required not both 1", a[0], a[1]);
    else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      if (pending[k]) begin
        pending[k] = 1'b0;
        restarts_left[k]--;
        start_xfer(k, madr[k] + 30'd1, 1, 1'b0);
      end else if (a[k] === 1'b1) begin
        total_cnt++;
        empty = (k == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
        if (empty || beats_left[k] == 0) begin
          $display("FAIL unexpected_ack: master %0d ack=1 required 0 (no pending beat)", k);
        end else begin
          if (k == 0) e = exp_q0.pop_front();
          else        e = exp_q1.pop_front();
          if (d[k] !== e) $display("FAIL read_data m%0d: got %h required %h", k, d[k], e);
          else pass_cnt++;
          beats_left[k]--;
          if (beats_left[k] == 0) begin
            mcyc[k] = 1'b0; mstb[k] = 1'b0; mcti[k] = 3'b000;
            grant_code = grant_code * 10 + k + 1;
            if (restarts_left[k] > 0) pending[k] = 1'b1;
          end else begin
            madr[k] = madr[k] + 30'd1;
            mdat[k] = {madr[k], 2'b00} ^ 32'h0F0F_0F0F;
            mcti[k] = (beats_left[k] == 1) ? 3'b111 : 3'b010;
            push_exp(k, madr[k]);
          end
        end
      end
    end
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    int n = 0;
    while ((beats_left[0] != 0 || beats_left[1] != 0 || pending[0] || pending[1]) && n < budget) begin
      @(negedge clk);
      service();
      n++;
    end
    total_cnt++;
    if (n >= budget) $display("FAIL %s_timeout: cycles=%0d required < %0d", tag, n, budget);
    else pass_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_masters();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_masters();
    rst = 1'b1;
    mcyc[0] = 1'b1; mstb[0] = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({s_cyc_o, s_stb_o, m0_ack, m1_ack} !== 4'b0000)
      $display("FAIL reset_idle: cyc/stb/ack0/ack1=%b required 0000", {s_cyc_o, s_stb_o, m0_ack, m1_ack});
    else pass_cnt++;
    total_cnt++;
    if ({m0_stall, m1_stall} !== 2'b11) $display("FAIL reset_stall: got %b required 11", {m0_stall, m1_stall});
    else pass_cnt++;
    total_cnt++;
    if (s_adr_o !== 30'h111) $display("FAIL idle_adr_mux: got %h required %h", s_adr_o, 30'h111);
    else pass_cnt++;
    mcyc[0] = 1'b0; mstb[0] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    ack_force = 1'b1;
    #1;
    total_cnt++;
    if ({m0_ack, m1_ack} !== 2'b00) $display("FAIL idle_ack_drop: got %b required 00", {m0_ack, m1_ack});
    else pass_cnt++;
    ack_force = 1'b0;
  endtask

  task automatic test_single();
    int n = 0;
    grant_code = 0;
    @(negedge clk);
    start_xfer(0, 30'h1, 1, 1'b1);
    mdat[0] = 32'hDEADBEEF;
    #1;
    total_cnt++;
    if (s_cyc_o !== 1'b0) $display("FAIL single_arb_latency: s_cyc=%b required 0", s_cyc_o);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({s_cyc_o, s_stb_o, s_we_o, s_sel_o} !== 7'b1111111 || s_adr_o !== 30'h1 || s_dat_o !== 32'hDEADBEEF)
      $display("FAIL single_request: cyc/stb/we/sel=%b adr=%h dat=%h required 1111111 1 deadbeef",
               {s_cyc_o, s_stb_o, s_we_o, s_sel_o}, s_adr_o, s_dat_o);
    else pass_cnt++;
    total_cnt++;
    if ({m0_stall, m1_stall} !== 2'b01) $display("FAIL single_stall: m0/m1 stall=%b required 01", {m0_stall, m1_stall});
    else pass_cnt++;
    service();
    while (beats_left[0] != 0 && n < 20) begin
      @(negedge clk);
      total_cnt++;
      if (m1_stall !== 1'b1) $display("FAIL single_m1_stall: got %b required 1", m1_stall);
      else pass_cnt++;
      service();
      n++;
    end
    total_cnt++;
    if (grant_code !== 1) $display("FAIL single_grant_order: got %0d required 1", grant_code);
    else pass_cnt++;
  endtask

  task automatic test_contention();
    int n = 0;
    do_reset();
    @(negedge clk);
    start_xfer(0, 30'h10, 1, 1'b1);
    start_xfer(1, 30'h20, 1, 1'b0);
    @(negedge clk);
    total_cnt++;
    if (s_adr_o !== 30'h10 || m1_stall !== 1'b1 || s_cyc_o !== 1'b1)
      $display("FAIL contention_first: adr=%h m1_stall=%b cyc=%b required 10 1 1", s_adr_o, m1_stall, s_cyc_o);
    else pass_cnt++;
    service();
    while (beats_left[0] != 0 && n < 20) begin
      @(negedge clk);
      service();
      n++;
    end
    #1;
    total_cnt++;
    if (s_cyc_o !== 1'b1 || s_adr_o !== 30'h20 || m0_stall !== 1'b1)
      $display("FAIL handover_same_cycle: cyc=%b adr=%h m0_stall=%b required 1 20 1", s_cyc_o, s_adr_o, m0_stall);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (s_cyc_o !== 1'b1 || s_adr_o !== 30'h20)
      $display("FAIL handover_no_idle: cyc=%b adr=%h required 1 20", s_cyc_o, s_adr_o);
    else pass_cnt++;
    service();
    run_until_idle(20, "contention");
    total_cnt++;
    if (grant_code !== 12) $display("FAIL contention_order: got %0d required 12", grant_code);
    else pass_cnt++;
  endtask

  task automatic test_alternation();
    int exp_code;
    grant_code = 0;
    @(negedge clk);
    restarts_left[0] = 2;
    restarts_left[1] = 2;
    start_xfer(0, 30'h30, 1, 1'b0);
    start_xfer(1, 30'h38, 1, 1'b0);
    run_until_idle(100, "alternation");
    total_cnt++;
    if (grant_code !== 121212) $display("FAIL alternation_order: got %0d required 121212", grant_code);
    else pass_cnt++;
    grant_code = 0;
    @(negedge clk);
    start_xfer(0, 30'h40, 1, 1'b0);
    run_until_idle(20, "solo");
    repeat (2) @(negedge clk);
    start_xfer(0, 30'h44, 1, 1'b0);
    start_xfer(1, 30'h48, 1, 1'b0);
    run_until_idle(30, "idle_contention");
`ifdef WB_ARBITER_RR_EN
    exp_code = 121;
`else
    exp_code = 112;
`endif
    total_cnt++;
    if (grant_code !== exp_code) $display("FAIL idle_contention_order: got %0d required %0d", grant_code, exp_code);
    else pass_cnt++;
  endtask

  task automatic test_burst();
    int n = 0;
    bit m0_started = 1'b0;
    logic [2:0] exp_cti;
    grant_code = 0;
    @(negedge clk);
    start_xfer(1, 30'h80, 4, 1'b0);
    while ((beats_left[0] != 0 || beats_left[1] != 0) && n < 100) begin
      @(negedge clk);
      if (beats_left[1] != 0) begin
        total_cnt++;
        if (m0_ack !== 1'b0 || m0_stall !== 1'b1)
          $display("FAIL burst_m0_blocked: ack=%b stall=%b required 0 1", m0_ack, m0_stall);
        else pass_cnt++;
        if (m1_ack === 1'b1) begin
          exp_cti = (beats_left[1] == 1) ? 3'b111 : 3'b010;
          total_cnt++;
          if (s_cti_o !== exp_cti) $display("FAIL burst_cti: got %b required %b", s_cti_o, exp_cti);
          else pass_cnt++;
        end
      end
      service();
      if (!m0_started && beats_left[1] == 3) begin
        start_xfer(0, 30'h90, 1, 1'b1);
        m0_started = 1'b1;
      end
      n++;
    end
    total_cnt++;
    if (n >= 100 || grant_code !== 21)
      $display("FAIL burst_order: got %0d after %0d cycles required 21", grant_code, n);
    else pass_cnt++;
  endtask

  task automatic test_reset_midburst();
    @(negedge clk);
    start_xfer(1, 30'hA0, 4, 1'b0);
    @(negedge clk); service();
    @(negedge clk); service();
    total_cnt++;
    if (s_cyc_o !== 1'b1 || s_adr_o[29:4] !== 26'hA)
      $display("FAIL midburst_owned: cyc=%b adr=%h required 1 a?", s_cyc_o, s_adr_o);
    else pass_cnt++;
    rst = 1'b1;
    ack_force = 1'b1;
    #1;
    total_cnt++;
    if ({s_cyc_o, s_stb_o, m1_ack, m1_stall, m0_ack} !== 5'b00010)
      $display("FAIL midburst_reset: cyc/stb/ack1/stall1/ack0=%b required 00010",
               {s_cyc_o, s_stb_o, m1_ack, m1_stall, m0_ack});
    else pass_cnt++;
    ack_force = 1'b0;
    clear_masters();
    @(negedge clk);
    rst = 1'b0;
    start_xfer(0, 30'hB0, 1, 1'b1);
    @(negedge clk);
    total_cnt++;
    if (s_cyc_o !== 1'b1 || s_adr_o !== 30'hB0)
      $display("FAIL post_reset_grant: cyc=%b adr=%h required 1 b0", s_cyc_o, s_adr_o);
    else pass_cnt++;
    service();
    run_until_idle(20, "post_reset");
  endtask

  initial begin
    clear_masters();
    test_reset();
    test_single();
    test_contention();
    test_alternation();
    test_burst();
    test_reset_midburst();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
